// File: rtl/wrr_pkt_scheduler_pkg.sv
// Shared state encoding and packed-field helper for the packet WRR scheduler.
// WRR_FIELD(vec, w, i) selects the i-th w-bit field of a flat packed vector.
package wrr_pkt_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

`define WRR_FIELD(vec, w, i) vec[(w)*(i) +: (w)]

// File: rtl/wrr_sched_credit.sv
// Per-requester packet credit counter: reload from the weight, count down per grant.
module wrr_sched_credit
  import wrr_pkt_scheduler_pkg::*;
#(
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    dec,
  input  logic [CREDIT_WIDTH-1:0] load_val,
  output logic                    nz
);

  logic [CREDIT_WIDTH-1:0] cnt_d, cnt_q;

  // reload wins over decrement; a zero counter never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CREDIT_WIDTH{1'b0}})) begin
      cnt_d = cnt_q - {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CREDIT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nz = |cnt_q;

endmodule

// File: rtl/wrr_pkt_scheduler.sv
// Packet-level weighted round-robin scheduler: one arbitration per packet,
// winner locked until its last beat is accepted, weights given as packet credits.
module wrr_pkt_scheduler
  import wrr_pkt_scheduler_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CREDIT_WIDTH*WIDTH-1:0] credits,
  input  logic [WIDTH-1:0]              s_valid,
  input  logic [WIDTH-1:0]              s_last,
  input  logic [DATA_WIDTH*WIDTH-1:0]   s_data,
  output logic [WIDTH-1:0]              s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [WIDTH-1:0]              owner,
  output logic                          reload
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] owner_d, owner_q;
  logic [WIDTH-1:0] enabled_s, cnt_nz_s, eligible_s, grant_s, dec_s;
  logic             reload_s;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_credit
      assign enabled_s[g] = |`WRR_FIELD(credits, CREDIT_WIDTH, g);

      wrr_sched_credit #(
        .CREDIT_WIDTH(CREDIT_WIDTH)
      ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .load     (reload_s),
        .dec      (dec_s[g]),
        .load_val (`WRR_FIELD(credits, CREDIT_WIDTH, g)),
        .nz       (cnt_nz_s[g])
      );
    end
  endgenerate

  assign eligible_s = s_valid & enabled_s & cnt_nz_s;
  // isolate the lowest set bit: lower index has priority
  assign grant_s    = eligible_s & (~eligible_s + {{(WIDTH-1){1'b0}}, 1'b1});

  // arbitration, credit reload and zero-latency beat steering from the locked owner
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    dec_s    = {WIDTH{1'b0}};
    reload_s = 1'b0;
    s_ready  = {WIDTH{1'b0}};
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = {DATA_WIDTH{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (|eligible_s) begin
          owner_d = grant_s;
          dec_s   = grant_s;
          state_d = ST_BUSY;
        end else if (|(s_valid & enabled_s)) begin
          // everyone still asking is out of credit: start a new round
          reload_s = ~rst;
        end else begin
          reload_s = 1'b0;
        end
      end
      ST_BUSY: begin
        // owner is one-hot, so an AND-OR mux selects its lane
        m_valid = |(s_valid & owner_q);
        m_last  = |(s_last & owner_q);
        s_ready = owner_q & {WIDTH{m_ready}};
        for (int i = 0; i < WIDTH; i++) begin
          m_data = m_data | (`WRR_FIELD(s_data, DATA_WIDTH, i) & {DATA_WIDTH{owner_q[i]}});
        end
        if (m_valid && m_ready && m_last) begin
          state_d = ST_IDLE;
          owner_d = {WIDTH{1'b0}};
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = {WIDTH{1'b0}};
      end
    endcase
  end

  // packet state and owner lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign owner  = owner_q;
  assign reload = reload_s;

endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
// Scoreboard bench for wrr_pkt_scheduler: a packet-level model predicts the beat
// stream per phase; a monitor compares every accepted beat and the ready/owner rules.
module tb_wrr_pkt_scheduler;

  localparam int W    = 4;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int MAXP = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW*W-1:0] credits;
  logic [W-1:0]    s_valid, s_last, s_ready;
  logic [DW*W-1:0] s_data;
  logic            m_valid, m_last, m_ready, reload;
  logic [DW-1:0]   m_data;
  logic [W-1:0]    owner;

  wrr_pkt_scheduler #(.WIDTH(W), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .credits(credits), .s_valid(s_valid), .s_last(s_last),
    .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .owner(owner), .reload(reload)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  own;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    reload_times[$];
  int    checks = 0, failures = 0, cyc = 0, reload_cnt = 0;
  int    npk[W], pidx[W], bidx[W], mcnt[W];
  int    plen[W][MAXP];
  int    mr_mode = 0;
  bit    gaps = 1'b0;
  int    tbase = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int i, input int p, input int b);
    int v;
    v = (i << 24) | (p << 16) | (b << 8) | 8'h5A;
    return DW'(v);
  endfunction

  function automatic int fld(input logic [CW*W-1:0] c, input int i);
    logic [CW*W-1:0] t;
    t = c >> (CW * i);
    return int'(t[CW-1:0]);
  endfunction

  // Packet-level reference: grant lowest requester with pending packet and credit,
  // otherwise reload every counter from its weight; nothing eligible ends the phase.
  task automatic model_phase(input logic [CW*W-1:0] cr0, input logic [CW*W-1:0] cr1,
                             input int switch_at, output int nrel);
    int              rem[W], done[W];
    int              win;
    bit              any_pend, go;
    logic [CW*W-1:0] cr;
    beat_t           e;
    nrel = 0;
    go   = 1'b1;
    for (int i = 0; i < W; i++) begin rem[i] = npk[i]; done[i] = 0; end
    while (go) begin
      cr       = (nrel >= switch_at) ? cr1 : cr0;
      win      = -1;
      any_pend = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
        if (rem[i] > 0 && fld(cr, i) != 0) begin
          any_pend = 1'b1;
          if (mcnt[i] > 0) win = i;
        end
      end
      if (win >= 0) begin
        for (int b = 0; b < plen[win][done[win]]; b++) begin
          e.own      = '0;
          e.own[win] = 1'b1;
          e.data     = mkdata(win, done[win], b);
          e.last     = (b == plen[win][done[win]] - 1);
          exp_q.push_back(e);
        end
        mcnt[win]--; rem[win]--; done[win]++;
      end else if (any_pend) begin
        for (int i = 0; i < W; i++) mcnt[i] = fld(cr, i);
        nrel++;
      end else begin
        go = 1'b0;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      if (pidx[i] < npk[i]) begin
        s_valid[i] = (gaps && bidx[i] > 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_last[i]  = (bidx[i] == plen[i][pidx[i]] - 1);
        s_data[DW*i +: DW] = mkdata(i, pidx[i], bidx[i]);
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
        s_data[DW*i +: DW] = '0;
      end
    end
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic step();
    logic [W-1:0] acc;
    @(negedge clk);
    acc = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      if (acc[i]) begin
        bidx[i]++;
        if (bidx[i] == plen[i][pidx[i]]) begin bidx[i] = 0; pidx[i]++; end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
    for (int i = 0; i < W; i++) begin npk[i] = 0; pidx[i] = 0; bidx[i] = 0; mcnt[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_phase(input string nm, input logic [CW*W-1:0] cr0, input logic [CW*W-1:0] cr1,
                           input bit do_switch, input int mode, input bit gp, input int tail);
    int nrel, rbase, n;
    bit switched;
    credits = cr0; mr_mode = mode; gaps = gp;
    for (int i = 0; i < W; i++) begin pidx[i] = 0; bidx[i] = 0; end
    model_phase(cr0, cr1, do_switch ? 1 : 1000, nrel);
    rbase = reload_cnt; tbase = reload_times.size(); switched = 1'b0; n = 0;
    drive();
    while (exp_q.size() > 0 && n < 4000) begin
      step();
      n++;
      if (do_switch && !switched && reload_cnt >= rbase + 1 && owner != '0) begin
        credits = cr1; switched = 1'b1;
      end
    end
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout remaining_beats=%0d expected=0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (tail) step();
    chk({nm, "_reload_count"}, 64'(reload_cnt - rbase), 64'(nrel));
    for (int i = 0; i < W; i++) npk[i] = 0;
    drive();
    step();
    step();
  endtask

  // monitor: every accepted beat must match the head of the expected queue
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (reload) begin reload_cnt++; reload_times.push_back(cyc); end
        chk("ready_follows_owner", 64'(s_ready), 64'(owner & {W{m_ready}}));
        chk("owner_onehot0", 64'($countones(owner) <= 1), 64'd1);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat actual owner=%b data=%h expected=no beat", owner, m_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_owner", 64'(owner), 64'(e.own));
            chk("beat_data", 64'(m_data), 64'(e.data));
            chk("beat_last", 64'(m_last), 64'(e.last));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    rst = 1'b1; credits = 16'h1112; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
    do_reset();

    // idle after reset with nobody valid: everything low, no reload
    repeat (3) begin
      @(negedge clk);
      chk("idle_reload", 64'(reload), 64'd0);
      chk("idle_owner", 64'(owner), 64'd0);
      chk("idle_m_valid", 64'(m_valid), 64'd0);
      chk("idle_m_data", 64'(m_data), 64'd0);
      chk("idle_m_last", 64'(m_last), 64'd0);
      chk("idle_s_ready", 64'(s_ready), 64'd0);
    end

    // reset in the middle of a packet clears outputs immediately
    @(posedge clk); #1;
    s_valid = 4'b0001; s_data[31:0] = 32'hDEAD_BEEF;
    n = 0;
    while (owner != 4'b0001 && n < 10) begin @(posedge clk); #1; n++; end
    chk("pre_rst_owner", 64'(owner), 64'd1);
    chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
    chk("pre_rst_m_data", 64'(m_data), 64'hDEAD_BEEF);
    rst = 1'b1; m_ready = 1'b1;
    #1;
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_reload", 64'(reload), 64'd0);
    do_reset();

    // weights 2,1,1,1, single-beat packets, two full rounds of 11 cycles
    for (int i = 0; i < W; i++) for (int p = 0; p < MAXP; p++) plen[i][p] = 1;
    npk[0] = 4; npk[1] = 2; npk[2] = 2; npk[3] = 2;
    run_phase("round_1112", 16'h1112, 16'h1112, 1'b0, 0, 1'b0, 6);
    chk("round_1112_reloads_seen", 64'(reload_times.size() - tbase), 64'd2);
    if (reload_times.size() >= tbase + 2)
      chk("round_1112_cycles", 64'(reload_times[tbase+1] - reload_times[tbase]), 64'd11);

    // 4-beat packet from requester 1 under toggling m_ready, requester 0 competing
    do_reset();
    npk[0] = 3; npk[1] = 1; plen[1][0] = 4;
    run_phase("lock_4beat", 16'h1112, 16'h1112, 1'b0, 1, 1'b0, 6);
    plen[1][0] = 1;

    // requesters 2 and 3 disabled; they stay valid afterwards and must stay idle
    do_reset();
    npk[0] = 6; npk[1] = 2; npk[2] = 3; npk[3] = 3;
    run_phase("disabled_0013", 16'h0013, 16'h0013, 1'b0, 0, 1'b0, 20);

    // single requester: reload, grant, beat per packet
    do_reset();
    npk[2] = 3;
    run_phase("single_req2", 16'h1111, 16'h1111, 1'b0, 0, 1'b0, 6);
    chk("single_req2_reloads_seen", 64'(reload_times.size() - tbase), 64'd3);
    if (reload_times.size() >= tbase + 3) begin
      chk("single_req2_gap_a", 64'(reload_times[tbase+1] - reload_times[tbase]), 64'd3);
      chk("single_req2_gap_b", 64'(reload_times[tbase+2] - reload_times[tbase+1]), 64'd3);
    end

    // weights change mid-round and take effect only at the next reload
    do_reset();
    for (int i = 0; i < W; i++) npk[i] = 5;
    run_phase("credit_change", 16'h1111, 16'h4444, 1'b1, 0, 1'b0, 6);

    // randomized phases; credit counters carry over between them
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      logic [CW*W-1:0] cr;
      for (int i = 0; i < W; i++) begin
        cr[CW*i +: CW] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        npk[i] = $urandom_range(0, 4);
        for (int p = 0; p < MAXP; p++) plen[i][p] = $urandom_range(1, 4);
      end
      run_phase("random", cr, cr, 1'b0, 2, 1'b1, 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wrr_pkt_scheduler.md
Name: wrr_pkt_scheduler

Overview:
Packet-level weighted round-robin scheduler that shares one downstream valid/ready stream among WIDTH upstream requesters.
Arbitration happens once per packet. The winner is then locked until its last beat is accepted.
Per-requester credit counters give weighting in packets. Lower index wins among requesters with credit.
Sits in front of any shared sink (bus master port, FIFO, serializer) in the common RTL library.

Parameters:
WIDTH, 4, number of requesters
DATA_WIDTH, 32, beat data width per requester
CREDIT_WIDTH, 4, width of each credit field and counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
credits  in  CREDIT_WIDTH*WIDTH  per-requester packet weight; field i = credits[CREDIT_WIDTH*(i+1)-1:CREDIT_WIDTH*i]
s_valid  in  WIDTH  per-requester beat valid
s_last  in  WIDTH  per-requester last beat of packet
s_data  in  DATA_WIDTH*WIDTH  per-requester beat data, packed like credits
s_ready  out  WIDTH  per-requester beat accept
m_valid  out  1  downstream beat valid
m_data  out  DATA_WIDTH  downstream beat data
m_last  out  1  downstream last beat
m_ready  in  1  downstream accept
owner  out  WIDTH  one-hot current packet owner; 0 when idle
reload  out  1  one-cycle pulse when credit counters reload

Behaviour:
Reset (asynchronous, immediate):
- state=IDLE, owner=0, all credit counters=0.
- s_ready=0, m_valid=0, m_last=0, m_data=0, reload=0.

Configuration:
- enabled[i] = (credits field i != 0). A disabled requester is never granted and is ignored by the reload rule.
- cnt_nz[i] = (counter i != 0).
- eligible = s_valid & enabled & cnt_nz.

IDLE:
- All outputs are low, as in reset.
- If eligible != 0:
  - Winner = lowest-index set bit of eligible.
  - Next edge: owner<=onehot(winner), counter[winner] decrements by 1, state<=BUSY.
- Else if (s_valid & enabled) != 0:
  - reload=1 this cycle (combinational).
  - Next edge: every counter i loads credits field i. No grant; stay IDLE.
  - The arbitration bubble after a reload is exactly 1 cycle.
- Else: hold.
- The first packet after reset therefore costs a reload cycle plus an arbitration cycle.

BUSY:
- m_valid = s_valid[owner]; m_data = s_data[owner]; m_last = s_last[owner].
- s_ready[owner] = m_ready; all other s_ready = 0. This path is combinational, so beats pass with zero latency.
- On m_valid & m_ready & m_last: next edge state<=IDLE, owner<=0.
- If s_valid[owner] drops mid-packet, m_valid drops and the lock is held (no timeout).
- Counters change only on grant or reload, never during BUSY.

Timing and width rules:
- Minimum 1 IDLE cycle between packets, so back-to-back single-beat packets run at 1 packet per 2 cycles.
- credits is sampled only at reload; changes mid-round have no effect until the next reload.
- Counters never underflow: decrement only on grant, and grant requires cnt_nz.
- Maximum credit 2^CREDIT_WIDTH-1.
- Simultaneous requests with credit: lower index wins. Each requester gets at most credits[i] packets per round.

Reset mid-packet: the packet is truncated immediately. Resending or discarding the partial packet is the upstream's responsibility.

Decomposition:
- Shared header/package holds:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
  - a field-extract helper (macro or function) for the packed credits/s_data slices.
- One natural sub-module, wrr_sched_credit: a CREDIT_WIDTH counter with async reset to 0, load, decrement and nz outputs. Instantiate WIDTH times in a generate loop.
- The lowest-set-bit select and the output muxes stay inline.

Test Plan:
1. Reset, all s_valid=0, credits=16'h1112 -> no reload, owner=0, all outputs 0. Assert rst mid-run -> outputs 0 in the same cycle.
2. credits=16'h1112, all four requesters continuously offer 1-beat packets, m_ready=1:
   - Grant order 0,0,1,2,3, reload, 0,0,1,...
   - reload pulses once per round; each packet is separated by exactly 1 idle cycle.
3. Requester 1 sends a 4-beat packet, m_ready toggles 1,0,1,0,..., requester 0 is valid throughout:
   - owner stays 4'b0010 until the 4th beat is accepted; s_ready[0] stays 0.
   - All 4 beats appear on m_data in order.
4. credits=16'h0013 (requesters 2 and 3 disabled), all valid:
   - Grants 0,0,0,1, reload, repeat. owner never shows bits 2 or 3.
   - Requesters 2 and 3 alone valid -> no reload, no grant.
5. credits=16'h1111, requester 2 alone valid for 3 packets:
   - reload, grant 2, reload, grant 2, reload, grant 2.
   - Per-packet overhead of 2 cycles confirmed.
6. Change credits from 16'h1111 to 16'h4444 mid-round -> current round keeps 1 packet each; the new weights apply only after the next reload pulse.
